hvac_ctrl: RTL and testbench

Parametrised, clocked successor to the combinational HVAC controller. Samples desired and actual temperature on a valid strobe and classifies the signed difference into heat/idle/cool demand levels. A state machine enforces minimum dwell time in every mode and a coast-down state between modes. Fan speed is ramped one step at a time rather than jumped. Sits between the temperature sensor front end and the heater/compressor/fan drivers.

---
 rtl/hvac_pkg.sv | 30 +++
 rtl/hvac_demand.sv | 63 ++++++
 rtl/hvac_ctrl.sv | 121 ++++++++++++
 tb/tb_hvac_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hvac_pkg.sv
// hvac_pkg: shared state encoding and demand type for the HVAC controller.
package hvac_pkg;

  // Controller states, fixed 2-bit encoding exposed on the mode output
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_HEAT  = 2'd1;
  localparam state_t ST_COOL  = 2'd2;
  localparam state_t ST_COAST = 2'd3;

  // Demand direction reported by the classifier
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_HEAT = 2'd1,
    DIR_COOL = 2'd2
  } dir_e;

  // Demand: direction plus level 1..3 (level is 0 when direction is NONE)
  typedef struct packed {
    dir_e       dir;
    logic [1:0] lvl;
  } demand_t;

  // One fan step from cur toward tgt; caller guarantees cur != tgt
  function automatic logic [1:0] step_toward(input logic [1:0] cur,
                                             input logic [1:0] tgt);
    return (tgt > cur) ? cur + 2'd1 : cur - 2'd1;
  endfunction

endpackage

// File: rtl/hvac_demand.sv
// hvac_demand: combinational classifier from the sampled temperature
// difference (and current state) to a heat/cool demand with level 1..3.
// Optional feature macro: HVAC_HYST_EN widens the exit threshold of
// HEAT/COOL by HYST; entry thresholds and levels are unaffected.
module hvac_demand
  import hvac_pkg::*;
#(
  parameter int TW   = 8,
  parameter int T1   = 2,
  parameter int T2   = 5,
  parameter int T3   = 9,
  parameter int HYST = 2
) (
  input  logic signed [TW:0] diff,
  input  logic [1:0]         state,
  output demand_t            dmd
);

`ifdef HVAC_HYST_EN
  localparam int HYST_EFF = HYST;
`else
  // Hysteresis disabled in this build: exit thresholds equal entry ones
  localparam int HYST_EFF = 0 * HYST;
`endif

  // Thresholds at the width of diff so comparisons stay signed and width-matched
  localparam logic signed [TW:0] P_T1      = (TW+1)'(T1);
  localparam logic signed [TW:0] P_T2      = (TW+1)'(T2);
  localparam logic signed [TW:0] P_T3      = (TW+1)'(T3);
  localparam logic signed [TW:0] N_T1      = (TW+1)'(-T1);
  localparam logic signed [TW:0] N_T2      = (TW+1)'(-T2);
  localparam logic signed [TW:0] N_T3      = (TW+1)'(-T3);
  localparam logic signed [TW:0] HEAT_EXIT = (TW+1)'(HYST_EFF - T1);
  localparam logic signed [TW:0] COOL_EXIT = (TW+1)'(T1 - HYST_EFF);

  logic signed [TW:0] heat_lim;
  logic signed [TW:0] cool_lim;

  // Pick the active band edges: the state being held gets the wider band
  always_comb begin
    heat_lim = N_T1;
    cool_lim = P_T1;
    if (state == ST_HEAT) heat_lim = HEAT_EXIT;
    if (state == ST_COOL) cool_lim = COOL_EXIT;
  end

  // Classify; heat is tested first so an overlapping band resolves to heat
  always_comb begin
    dmd = '{dir: DIR_NONE, lvl: 2'd0};
    if (diff < heat_lim) begin
      dmd.dir = DIR_HEAT;
      if (diff < N_T3)      dmd.lvl = 2'd3;
      else if (diff < N_T2) dmd.lvl = 2'd2;
      else                  dmd.lvl = 2'd1;
    end else if (diff > cool_lim) begin
      dmd.dir = DIR_COOL;
      if (diff > P_T3)      dmd.lvl = 2'd3;
      else if (diff > P_T2) dmd.lvl = 2'd2;
      else                  dmd.lvl = 2'd1;
    end
  end

endmodule

// File: rtl/hvac_ctrl.sv
// hvac_ctrl: clocked HVAC controller. Samples desired/actual temperature on
// valid, classifies the difference, runs an IDLE/HEAT/COOL/COAST state
// machine with minimum dwell per state, and ramps fan speed one step per
// RAMP_DIV cycles. Optional feature macro: HVAC_HYST_EN (see hvac_demand).
module hvac_ctrl
  import hvac_pkg::*;
#(
  parameter int TW        = 8,
  parameter int T1        = 2,
  parameter int T2        = 5,
  parameter int T3        = 9,
  parameter int HYST      = 2,
  parameter int MIN_DWELL = 16,
  parameter int RAMP_DIV  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic [TW-1:0] dtemp,
  input  logic [TW-1:0] atemp,
  output logic [1:0]    speed,
  output logic          heat,
  output logic          cool,
  output logic          idle,
  output logic [1:0]    mode
);

  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

  logic signed [TW:0] diff_now;
  logic signed [TW:0] diff_q;
  demand_t            dmd;
  state_t             state;
  state_t             nstate;
  logic [DW-1:0]      dwell;
  logic               dwell_ok;
  logic [RW-1:0]      ramp_cnt;
  logic [1:0]         target;

  // Sign-extend by one bit before subtracting so extremes never wrap
  assign diff_now = $signed({atemp[TW-1], atemp}) - $signed({dtemp[TW-1], dtemp});

  // Sample register: demand stays frozen at the last valid sample
  always_ff @(posedge clk) begin
    if (rst)        diff_q <= '0;
    else if (valid) diff_q <= diff_now;
  end

  hvac_demand #(
    .TW(TW), .T1(T1), .T2(T2), .T3(T3), .HYST(HYST)
  ) u_demand (
    .diff  (diff_q),
    .state (state),
    .dmd   (dmd)
  );

  assign dwell_ok = (dwell == DWELL_MAX);

  // Next-state: every exit waits for dwell; HEAT and COOL only leave via COAST
  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: begin
        if (dwell_ok) begin
          if (dmd.dir == DIR_HEAT)      nstate = ST_HEAT;
          else if (dmd.dir == DIR_COOL) nstate = ST_COOL;
        end
      end
      ST_HEAT:  if (dwell_ok && dmd.dir != DIR_HEAT) nstate = ST_COAST;
      ST_COOL:  if (dwell_ok && dmd.dir != DIR_COOL) nstate = ST_COAST;
      ST_COAST: if (dwell_ok && speed == 2'd0)       nstate = ST_IDLE;
      default:  nstate = ST_IDLE;
    endcase
  end

  // Fan target: only a demand matching the active mode drives the fan
  always_comb begin
    target = 2'd0;
    if (state == ST_HEAT && dmd.dir == DIR_HEAT) target = dmd.lvl;
    if (state == ST_COOL && dmd.dir == DIR_COOL) target = dmd.lvl;
  end

  // State, dwell counter and registered mode indicators
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      dwell <= '0;
      heat  <= 1'b0;
      cool  <= 1'b0;
      idle  <= 1'b1;
    end else begin
      state <= nstate;
      if (nstate != state) dwell <= '0;
      else if (!dwell_ok)  dwell <= dwell + DW'(1);
      heat  <= (nstate == ST_HEAT);
      cool  <= (nstate == ST_COOL);
      idle  <= (nstate == ST_IDLE);
    end
  end

  // Fan ramp: one step per RAMP_DIV cycles; a target change mid-ramp keeps the count
  always_ff @(posedge clk) begin
    if (rst) begin
      speed    <= 2'd0;
      ramp_cnt <= '0;
    end else if (speed == target) begin
      ramp_cnt <= '0;
    end else if (ramp_cnt == RAMP_LAST) begin
      speed    <= step_toward(speed, target);
      ramp_cnt <= '0;
    end else begin
      ramp_cnt <= ramp_cnt + RW'(1);
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_hvac_ctrl.sv
// tb_hvac_ctrl: directed scenarios plus randomized stimulus, every cycle
// compared against a behavioural integer model of the controller.
module tb_hvac_ctrl;

  localparam int TW = 8, T1 = 2, T2 = 5, T3 = 9, HYST = 2;
  localparam int MIN_DWELL = 16, RAMP_DIV = 4;
  localparam int M_IDLE = 0, M_HEAT = 1, M_COOL = 2, M_COAST = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [TW-1:0] dtemp = '0;
  logic [TW-1:0] atemp = '0;
  logic [1:0]    speed;
  logic          heat, cool, idle;
  logic [1:0]    mode;

  int n_chk = 0;
  int n_pass = 0;

  // model state
  int m_diff = 0, m_mode = M_IDLE, m_dwell = 0, m_speed = 0, m_rc = 0;
  int cur_d = 20, cur_a = 20;

  hvac_ctrl #(
    .TW(TW), .T1(T1), .T2(T2), .T3(T3), .HYST(HYST),
    .MIN_DWELL(MIN_DWELL), .RAMP_DIV(RAMP_DIV)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .dtemp(dtemp), .atemp(atemp),
    .speed(speed), .heat(heat), .cool(cool), .idle(idle), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Signed demand: negative = heat level, positive = cool level, 0 = none
  function automatic int dem(input int d, input int md);
    int heat_lim, cool_lim;
    heat_lim = -T1;
    cool_lim = T1;
`ifdef HVAC_HYST_EN
    if (md == M_HEAT) heat_lim = HYST - T1;
    if (md == M_COOL) cool_lim = T1 - HYST;
`else
    if (md < 0) heat_lim = 0;
`endif
    if (d < -T3) return -3;
    if (d < -T2) return -2;
    if (d < heat_lim) return -1;
    if (d <= cool_lim) return 0;
    if (d <= T2) return 1;
    if (d <= T3) return 2;
    return 3;
  endfunction

  task automatic model_step(input logic r, input logic v, input int d, input int a);
    int lvl, tgt, nm;
    if (r) begin
      m_diff = 0; m_mode = M_IDLE; m_dwell = 0; m_speed = 0; m_rc = 0;
      return;
    end
    lvl = dem(m_diff, m_mode);
    if (m_mode == M_HEAT && lvl < 0)      tgt = -lvl;
    else if (m_mode == M_COOL && lvl > 0) tgt = lvl;
    else                                  tgt = 0;
    nm = m_mode;
    if (m_dwell == MIN_DWELL) begin
      case (m_mode)
        M_IDLE:  nm = (lvl < 0) ? M_HEAT : (lvl > 0) ? M_COOL : M_IDLE;
        M_HEAT:  if (lvl >= 0) nm = M_COAST;
        M_COOL:  if (lvl <= 0) nm = M_COAST;
        default: if (m_speed == 0) nm = M_IDLE;
      endcase
    end
    if (nm != m_mode)            m_dwell = 0;
    else if (m_dwell < MIN_DWELL) m_dwell++;
    if (m_speed == tgt) m_rc = 0;
    else if (m_rc == RAMP_DIV - 1) begin
      m_speed += (tgt > m_speed) ? 1 : -1;
      m_rc = 0;
    end else m_rc++;
    m_mode = nm;
    if (v) m_diff = a - d;
  endtask

  // One clock: drive on the falling edge, compare shortly after the rising edge
  task automatic cyc(input logic r, input logic v, input int d, input int a);
    @(negedge clk);
    rst = r; valid = v; dtemp = d[7:0]; atemp = a[7:0];
    if (v) begin cur_d = d; cur_a = a; end
    @(posedge clk);
    model_step(r, v, d, a);
    #1;
    check("mode",  int'(mode),  m_mode);
    check("speed", int'(speed), m_speed);
    check("heat",  int'(heat),  (m_mode == M_HEAT)  ? 1 : 0);
    check("cool",  int'(cool),  (m_mode == M_COOL)  ? 1 : 0);
    check("idle",  int'(idle),  (m_mode == M_IDLE)  ? 1 : 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, cur_d, cur_a);
  endtask

  task automatic sample(input int d, input int a);
    cyc(1'b0, 1'b1, d, a);
  endtask

  initial begin
    // reset
    cyc(1'b1, 1'b0, 20, 20);
    cyc(1'b1, 1'b0, 20, 20);
    check("rst_mode", int'(mode), 0);
    check("rst_speed", int'(speed), 0);
    check("rst_idle", int'(idle), 1);

    // equal temperatures: stays idle
    sample(20, 20);
    run(50);
    check("eq_mode", int'(mode), M_IDLE);
    check("eq_speed", int'(speed), 0);

    // diff=-12: heat one edge after the sample, speed 1,2,3 every 4 cycles
    sample(20, 8);
    check("heat_lat0", int'(heat), 0);
    run(1);
    check("heat_entry", int'(heat), 1);
    run(4);  check("ramp1", int'(speed), 1);
    run(4);  check("ramp2", int'(speed), 2);
    run(4);  check("ramp3", int'(speed), 3);
    run(10);

    // diff=+10 from HEAT L3: coast, ramp down, idle, then cool L3
    sample(20, 30);
    run(1);
    check("coast_entry", int'(mode), M_COAST);
    run(60);
    check("cool_mode", int'(mode), M_COOL);
    check("cool_speed", int'(speed), 3);

    // back to heat, then diff=-1 exercises the exit threshold
    sample(20, 8);
    run(60);
    check("heat_again", int'(mode), M_HEAT);
    sample(20, 19);
    run(40);
`ifdef HVAC_HYST_EN
    check("hyst_hold_mode", int'(mode), M_HEAT);
    check("hyst_hold_speed", int'(speed), 1);
`else
    check("nohyst_exit_mode", int'(mode), M_IDLE);
    check("nohyst_exit_speed", int'(speed), 0);
`endif
    sample(20, 20);
    run(40);
    check("diff0_idle", int'(mode), M_IDLE);

    // extreme inputs: no wrap in the difference
    sample(127, -128);
    run(30);
    check("ovf_heat_mode", int'(mode), M_HEAT);
    check("ovf_heat_speed", int'(speed), 3);
    sample(-128, 127);
    run(60);
    check("ovf_cool_mode", int'(mode), M_COOL);
    check("ovf_cool_speed", int'(speed), 3);

    // cool L2 drops speed to 2, reset mid-state, then full dwell before re-entry
    sample(20, 27);
    run(4);
    check("l2_speed", int'(speed), 2);
    cyc(1'b1, 1'b0, 20, 27);
    check("mrst_mode", int'(mode), M_IDLE);
    check("mrst_speed", int'(speed), 0);
    check("mrst_idle", int'(idle), 1);
    check("mrst_cool", int'(cool), 0);
    sample(20, 32);
    run(15);
    check("redwell_hold", int'(mode), M_IDLE);
    run(1);
    check("redwell_entry", int'(mode), M_COOL);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int d, a;
      logic r, v;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) begin
        d = int'($urandom_range(0, 255)) - 128;
        a = int'($urandom_range(0, 255)) - 128;
      end else begin
        d = int'($urandom_range(0, 60)) - 30;
        a = d + int'($urandom_range(0, 30)) - 15;
      end
      cyc(r, v, d, a);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
